// File: rtl/cpu_bus_responder_pkg.sv
// rtl/cpu_bus_responder_pkg.sv - shared encodings for the CPU bus responder
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Active DSACK lines per port size; bit 0 = DSACK1, bit 1 = DSACK0
    localparam logic [1:0] DSACK_16 = 2'b01;
    localparam logic [1:0] DSACK_32 = 2'b11;

    localparam int MAX_WAIT_STATES = 15;
    localparam int MIN_SYNC_STAGES = 2;

    // Keep the wait-state load inside the 4-bit counter range
    function automatic logic [3:0] clamp_wait(input int ws);
        if (ws < 0)
            return 4'd0;
        else if (ws > MAX_WAIT_STATES)
            return 4'(MAX_WAIT_STATES);
        else
            return 4'(ws);
    endfunction

endpackage

// File: rtl/cpu_bus_responder_bus_sync.sv
// rtl/cpu_bus_responder_bus_sync.sv - multi-stage synchroniser with preset to 1
module bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the asynchronous strobe through the chain; idle level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= '1;
        else
            sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - 68030-style register-space bus responder
import cpu_bus_responder_pkg::*;

module cpu_bus_responder #(
    parameter int WAIT_STATES = 2,
    parameter bit PORT32      = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic SCLK,
    input  logic RST,
    input  logic AS_,
    input  logic DS_,
    input  logic RW,
    input  logic CS,
    output logic DSACK0_,
    output logic DSACK1_,
    output logic DSACK_OE,
    output logic RD_STB,
    output logic WR_STB,
    output logic BUSY
);

    localparam int         SYNC_N    = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam logic [3:0] WAIT_LOAD = clamp_wait(WAIT_STATES);
    localparam logic [1:0] ACK_CODE  = PORT32 ? DSACK_32 : DSACK_16;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       dir_read;
    logic       as_s;
    logic       ds_s;

    bus_sync #(.STAGES(SYNC_N)) u_as_sync (
        .clk (SCLK),
        .rst (RST),
        .d   (AS_),
        .q   (as_s)
    );

    bus_sync #(.STAGES(SYNC_N)) u_ds_sync (
        .clk (SCLK),
        .rst (RST),
        .d   (DS_),
        .q   (ds_s)
    );

    // Bus cycle sequencer: qualify, wait, acknowledge, then precharge and release
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            dir_read <= 1'b0;
            DSACK0_  <= 1'b1;
            DSACK1_  <= 1'b1;
            DSACK_OE <= 1'b0;
            RD_STB   <= 1'b0;
            WR_STB   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            RD_STB <= 1'b0;
            WR_STB <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Writes are held off until the data strobe says the bus data is valid
                    if (!as_s && CS && (RW || !ds_s)) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        dir_read <= RW;
                        RD_STB   <= RW;
                        BUSY     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (as_s) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (wait_cnt == 4'd0) begin
                        state    <= ST_ACK;
                        DSACK1_  <= ~ACK_CODE[0];
                        DSACK0_  <= ~ACK_CODE[1];
                        DSACK_OE <= 1'b1;
                        WR_STB   <= ~dir_read;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    // Drive DSACK high for one clock before tri-stating the pads
                    if (as_s) begin
                        state   <= ST_RELEASE;
                        DSACK1_ <= 1'b1;
                        DSACK0_ <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_IDLE;
                    DSACK_OE <= 1'b0;
                    BUSY     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - scoreboard bench for cpu_bus_responder
module tb_cpu_bus_responder;

    logic SCLK = 1'b0;
    logic RST  = 1'b1;
    logic AS_  = 1'b1;
    logic DS_  = 1'b1;
    logic RW   = 1'b1;
    logic CS   = 1'b0;

    logic a_d0, a_d1, a_oe, a_rd, a_wr, a_busy;
    logic b_d0, b_d1, b_oe, b_rd, b_wr, b_busy;
    logic c_d0, c_d1, c_oe, c_rd, c_wr, c_busy;

    logic [5:0] obs_a, obs_b, obs_c;
    assign obs_a = {a_d1, a_d0, a_oe, a_rd, a_wr, a_busy};
    assign obs_b = {b_d1, b_d0, b_oe, b_rd, b_wr, b_busy};
    assign obs_c = {c_d1, c_d0, c_oe, c_rd, c_wr, c_busy};

    localparam logic [5:0] IDLE_V = 6'b110000;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    always #5 SCLK = ~SCLK;

    cpu_bus_responder #(.WAIT_STATES(2), .PORT32(1'b0), .SYNC_STAGES(2)) dut_a (
        .SCLK(SCLK), .RST(RST), .AS_(AS_), .DS_(DS_), .RW(RW), .CS(CS),
        .DSACK0_(a_d0), .DSACK1_(a_d1), .DSACK_OE(a_oe),
        .RD_STB(a_rd), .WR_STB(a_wr), .BUSY(a_busy)
    );

    cpu_bus_responder #(.WAIT_STATES(8), .PORT32(1'b0), .SYNC_STAGES(2)) dut_b (
        .SCLK(SCLK), .RST(RST), .AS_(AS_), .DS_(DS_), .RW(RW), .CS(CS),
        .DSACK0_(b_d0), .DSACK1_(b_d1), .DSACK_OE(b_oe),
        .RD_STB(b_rd), .WR_STB(b_wr), .BUSY(b_busy)
    );

    cpu_bus_responder #(.WAIT_STATES(0), .PORT32(1'b1), .SYNC_STAGES(2)) dut_c (
        .SCLK(SCLK), .RST(RST), .AS_(AS_), .DS_(DS_), .RW(RW), .CS(CS),
        .DSACK0_(c_d0), .DSACK1_(c_d1), .DSACK_OE(c_oe),
        .RD_STB(c_rd), .WR_STB(c_wr), .BUSY(c_busy)
    );

    function automatic logic [5:0] vec(input bit d1n, input bit d0n, input bit oe,
                                       input bit rd, input bit wr, input bit busy);
        return {d1n, d0n, oe, rd, wr, busy};
    endfunction

    task automatic idle_gap(input int n);
        AS_ = 1'b1;
        DS_ = 1'b1;
        CS  = 1'b0;
        RW  = 1'b1;
        repeat (n) @(posedge SCLK);
        #1;
    endtask

    task automatic test_reset;
        logic [5:0] want;
        RST = 1'b1;
        repeat (3) @(posedge SCLK);
        #1;
        exp_q.push_back(IDLE_V);
        exp_q.push_back(IDLE_V);
        exp_q.push_back(IDLE_V);
        want = exp_q.pop_front();
        checks++;
        if (obs_a !== want) begin errors++; $display("FAIL reset_a got %b want %b", obs_a, want); end
        want = exp_q.pop_front();
        checks++;
        if (obs_b !== want) begin errors++; $display("FAIL reset_b got %b want %b", obs_b, want); end
        want = exp_q.pop_front();
        checks++;
        if (obs_c !== want) begin errors++; $display("FAIL reset_c got %b want %b", obs_c, want); end
        RST = 1'b0;
        idle_gap(3);
    endtask

    // Read on dut_a: AS_ low before edge 0, high before edge 8
    task automatic test_read;
        logic [5:0] want;
        for (int e = 0; e < 13; e++) begin
            AS_ = (e >= 8);
            DS_ = (e >= 8);
            RW  = 1'b1;
            CS  = 1'b1;
            exp_q.push_back(vec(!(e >= 5 && e <= 9), 1'b1, (e >= 5 && e <= 10),
                                (e == 2), 1'b0, (e >= 2 && e <= 10)));
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_a !== want) begin errors++; $display("FAIL read e%0d got %b want %b", e, obs_a, want); end
        end
        idle_gap(6);
    endtask

    // Write on dut_a with DS_ lagging by 3 clocks and RW flipping mid-cycle
    task automatic test_write;
        logic [5:0] want;
        for (int e = 0; e < 16; e++) begin
            AS_ = (e >= 11);
            DS_ = !(e >= 3 && e < 11);
            RW  = (e >= 6);
            CS  = 1'b1;
            exp_q.push_back(vec(!(e >= 8 && e <= 12), 1'b1, (e >= 8 && e <= 13),
                                1'b0, (e == 8), (e >= 5 && e <= 13)));
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_a !== want) begin errors++; $display("FAIL write e%0d got %b want %b", e, obs_a, want); end
        end
        idle_gap(6);
    endtask

    task automatic test_cs_miss;
        logic [5:0] want;
        for (int e = 0; e < 10; e++) begin
            AS_ = 1'b0;
            DS_ = 1'b0;
            RW  = e[0];
            CS  = 1'b0;
            exp_q.push_back(IDLE_V);
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_a !== want) begin errors++; $display("FAIL cs_miss e%0d got %b want %b", e, obs_a, want); end
        end
        idle_gap(6);
    endtask

    // Write on dut_b (8 wait states) aborted by AS_ rising before edge 5
    task automatic test_abort;
        logic [5:0] want;
        for (int e = 0; e < 14; e++) begin
            AS_ = (e >= 5);
            DS_ = (e >= 5);
            RW  = 1'b0;
            CS  = 1'b1;
            exp_q.push_back(vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (e >= 2 && e <= 6)));
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_b !== want) begin errors++; $display("FAIL abort e%0d got %b want %b", e, obs_b, want); end
        end
        idle_gap(6);
    endtask

    // 32-bit port, zero wait states on dut_c
    task automatic test_port32;
        logic [5:0] want;
        for (int e = 0; e < 11; e++) begin
            AS_ = (e >= 6);
            DS_ = 1'b1;
            RW  = 1'b1;
            CS  = 1'b1;
            exp_q.push_back(vec(!(e >= 3 && e <= 7), !(e >= 3 && e <= 7), (e >= 3 && e <= 8),
                                (e == 2), 1'b0, (e >= 2 && e <= 8)));
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_c !== want) begin errors++; $display("FAIL port32 e%0d got %b want %b", e, obs_c, want); end
        end
        idle_gap(6);
    endtask

    task automatic test_reset_mid_ack;
        logic [5:0] want;
        for (int e = 0; e < 7; e++) begin
            AS_ = 1'b0;
            DS_ = 1'b1;
            RW  = 1'b1;
            CS  = 1'b1;
            exp_q.push_back(vec(!(e >= 5), 1'b1, (e >= 5), (e == 2), 1'b0, (e >= 2)));
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_a !== want) begin errors++; $display("FAIL pre_rst e%0d got %b want %b", e, obs_a, want); end
        end
        #2;
        RST = 1'b1;
        #1;
        exp_q.push_back(IDLE_V);
        exp_q.push_back(IDLE_V);
        want = exp_q.pop_front();
        checks++;
        if (obs_a !== want) begin errors++; $display("FAIL async_rst_a got %b want %b", obs_a, want); end
        want = exp_q.pop_front();
        checks++;
        if (obs_c !== want) begin errors++; $display("FAIL async_rst_c got %b want %b", obs_c, want); end
        AS_ = 1'b1;
        CS  = 1'b0;
        #1;
        RST = 1'b0;
        for (int e = 0; e < 4; e++) begin
            exp_q.push_back(IDLE_V);
            @(posedge SCLK);
            #1;
            want = exp_q.pop_front();
            checks++;
            if (obs_a !== want) begin errors++; $display("FAIL post_rst e%0d got %b want %b", e, obs_a, want); end
        end
        test_read();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_cs_miss();
        test_abort();
        test_port32();
        test_reset_mid_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
